divider_128by64: RTL and testbench

//  Sequential restoring divider, the inverse of multiplier_64.

---
 rtl/divider_128by64.sv | 152 +++++++++++++++
 tb/tb_divider_128by64.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divider_128by64.sv
// Sequential restoring divider: 2*WIDTH-bit unsigned dividend by WIDTH-bit divisor.
// Produces one quotient bit per clock; valid/ready handshakes on input and output.
module divider_128by64 #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow,
  output logic [1:0]         dbg_state_o
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its data stable until that edge, and ready never
  // depends combinationally on valid (both ready and out_valid are registers).

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH:0]     prem_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               div_zero_q;
  logic               overflow_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;

  logic [WIDTH+1:0]   trial_in;
  logic [WIDTH+1:0]   trial_diff;
  logic               trial_neg;
  logic [WIDTH:0]     prem_d;
  logic [WIDTH-1:0]   shreg_d;
  logic               accept;
  logic [WIDTH-1:0]   dividend_hi;
  logic [WIDTH-1:0]   dividend_lo;

  assign accept      = in_valid && in_ready_q;
  assign dividend_hi = dividend[2*WIDTH-1:WIDTH];
  assign dividend_lo = dividend[WIDTH-1:0];

  // The partial remainder is always below the divisor, so its top bit is zero and
  // the extra headroom bit of trial_diff acts purely as the borrow.
  // The shift register holds the unconsumed dividend bits in its upper part and
  // collects quotient bits from the bottom; after WIDTH steps it is the quotient.
  always_comb begin
    trial_in   = {prem_q, shreg_q[WIDTH-1]};
    trial_diff = trial_in - {2'b00, divisor_q};
    trial_neg  = trial_diff[WIDTH+1];
    prem_d     = trial_neg ? trial_in[WIDTH:0] : trial_diff[WIDTH:0];
    shreg_d    = {shreg_q[WIDTH-2:0], ~trial_neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prem_q      <= '0;
      shreg_q     <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            divisor_q  <= divisor;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend_lo;
              div_zero_q  <= 1'b1;
              overflow_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (dividend_hi >= divisor) begin
              // Quotient would not fit in WIDTH bits.
              quotient_q  <= '1;
              remainder_q <= '0;
              div_zero_q  <= 1'b0;
              overflow_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              prem_q  <= {1'b0, dividend_hi};
              shreg_q <= dividend_lo;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= S_RUN;
            end
          end
        end

        S_RUN: begin
          prem_q  <= prem_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quotient_q  <= shreg_d;
            remainder_q <= prem_d[WIDTH-1:0];
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_zero    = div_zero_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divider_128by64.sv
// Bench for divider_128by64: table of operations with expected results, a scoreboard
// queue, plus hand-written back-pressure and mid-operation reset sequences.
module tb_divider_128by64;

  localparam int W  = 64;
  localparam int NV = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   dividend = '0;
  logic [W-1:0]     divisor = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_zero;
  logic             overflow;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  divider_128by64 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_zero    (div_zero),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // Result record layout: {div_zero, overflow, quotient, remainder}
  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [2*W+1:0] exp;
    int             hold;
  } vec_t;

  vec_t           vecs [NV];
  logic [2*W+1:0] exp_q [$];
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic chk(input string name, input logic [2*W+1:0] act, input logic [2*W+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W+1:0] model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    logic [2*W-1:0] q;
    logic [2*W-1:0] r;
    if (dvs == '0) return {1'b1, 1'b0, {W{1'b1}}, dvd[W-1:0]};
    if (dvd[2*W-1:W] >= dvs) return {1'b0, 1'b1, {W{1'b1}}, {W{1'b0}}};
    q = dvd / {{W{1'b0}}, dvs};
    r = dvd % {{W{1'b0}}, dvs};
    return {2'b00, q[W-1:0], r[W-1:0]};
  endfunction

  function automatic logic [2*W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_op(input string name, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [2*W+1:0] exp, input int hold);
    int             lat;
    int             exp_lat;
    logic           bad;
    logic [2*W+1:0] got;
    logic [2*W+1:0] want;
    exp_lat = (dvs == '0 || dvd[2*W-1:W] >= dvs) ? 1 : W + 1;
    chk({name, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = (hold == 0);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    // Keep presenting garbage: it must be ignored while busy.
    dividend = rand128();
    divisor  = {$urandom, $urandom};
    lat = 1;
    bad = 1'b0;
    while (!out_valid && lat < 200) begin
      bad = bad | in_ready;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    want = exp_q.pop_front();
    if (!out_valid) begin
      chk({name, "_timeout"}, out_valid, 1'b1);
      return;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_in_ready_busy"}, bad | in_ready, 1'b0);
    got = {div_zero, overflow, quotient, remainder};
    chk({name, "_result"}, got, want);
    if (hold > 0) begin
      bad = 1'b0;
      repeat (hold) begin
        in_valid = 1'b1;
        dividend = rand128();
        divisor  = {$urandom, $urandom};
        @(negedge clk);
        if ({div_zero, overflow, quotient, remainder} !== got || !out_valid || in_ready) bad = 1'b1;
      end
      in_valid = 1'b0;
      chk({name, "_hold_stable"}, bad, 1'b0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, "_post_valid"}, out_valid, 1'b0);
    chk({name, "_post_ready"}, in_ready, 1'b1);
    if (hold > 0) begin
      @(negedge clk);
      chk({name, "_single_handshake"}, out_valid, 1'b0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r_dvs;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    vecs[0]  = '{dvd: 128'd1000, dvs: 64'd7, exp: {2'b00, 64'd142, 64'd6}, hold: 0};
    vecs[1]  = '{dvd: 128'hFFFFFFFFFFFFFFFE_0000000000000001, dvs: {W{1'b1}},
                 exp: {2'b00, {W{1'b1}}, 64'd0}, hold: 0};
    vecs[2]  = '{dvd: 128'h1234, dvs: 64'd0, exp: {2'b10, {W{1'b1}}, 64'h1234}, hold: 0};
    vecs[3]  = '{dvd: 128'h1_0000000000000000, dvs: 64'd1, exp: {2'b01, {W{1'b1}}, 64'd0}, hold: 0};
    vecs[4]  = '{dvd: 128'd1000, dvs: 64'd7, exp: {2'b00, 64'd142, 64'd6}, hold: 10};
    vecs[5]  = '{dvd: 128'd0, dvs: 64'd5, exp: {2'b00, 64'd0, 64'd0}, hold: 0};
    vecs[6]  = '{dvd: {64'd4, {W{1'b1}}}, dvs: 64'd5, exp: {2'b00, {W{1'b1}}, 64'd4}, hold: 0};
    vecs[7]  = '{dvd: {{W{1'b1}}, 64'd0}, dvs: {W{1'b1}}, exp: {2'b01, {W{1'b1}}, 64'd0}, hold: 0};
    vecs[8]  = '{dvd: 128'd3, dvs: 64'd10, exp: {2'b00, 64'd0, 64'd3}, hold: 0};
    vecs[9]  = '{dvd: 128'hDEAD_0000_0000_0000_0000_0000_BEEF_CAFE, dvs: 64'd0,
                 exp: {2'b10, {W{1'b1}}, 64'h0000_0000_BEEF_CAFE}, hold: 3};
    for (int i = 10; i < NV; i++) begin
      r_dvs = {$urandom, $urandom};
      if (r_dvs == '0) r_dvs = 64'd1;
      r_hi  = {$urandom, $urandom} % r_dvs;
      r_lo  = {$urandom, $urandom};
      vecs[i] = '{dvd: {r_hi, r_lo}, dvs: r_dvs, exp: model({r_hi, r_lo}, r_dvs), hold: 0};
    end

    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {div_zero, overflow, quotient, remainder}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].exp, vecs[i].hold);
    end

    // Abort an operation with reset partway through the RUN phase.
    in_valid  = 1'b1;
    dividend  = 128'd1000;
    divisor   = 64'd7;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("abort_in_run", dbg_state, 2'd1);
    chk("abort_no_result_yet", out_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_outputs", {div_zero, overflow, quotient, remainder}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after_reset", 128'd50, 64'd5, {2'b00, 64'd10, 64'd0}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
